// File: rtl/ysyx_23060096_ifu_if.sv
// ysyx_23060096_ifu_if: bundles the IFU's instruction-memory request/response
// channel, the fetched-instruction channel to decode and the redirect input
// from execute. "master" is the IFU's view and "slave" is the surrounding
// core/memory view.
interface ysyx_23060096_ifu_if;
  // Instruction-memory request channel
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;

  // Instruction-memory response channel
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        imem_rsp_err;

  // Fetched instruction towards decode
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic        out_fault;

  // PC redirect from execute
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  modport master (
    output imem_req_valid,
    output imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid,
    input  imem_rsp_data,
    input  imem_rsp_err,
    output out_valid,
    output out_pc,
    output out_inst,
    output out_fault,
    input  out_ready,
    input  redirect_valid,
    input  redirect_pc
  );

  modport slave (
    input  imem_req_valid,
    input  imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid,
    output imem_rsp_data,
    output imem_rsp_err,
    input  out_valid,
    input  out_pc,
    input  out_inst,
    input  out_fault,
    output out_ready,
    output redirect_valid,
    output redirect_pc
  );
endinterface

// File: rtl/ysyx_23060096_ifu.sv
// ysyx_23060096_ifu: instruction fetch unit for the single-issue core.
// Holds the PC, issues one instruction-memory read at a time, captures the
// returned word and presents {pc, inst, fault} to decode. Redirects from
// execute replace the PC and cause any in-flight response to be dropped.
// Every output is either a register or a decode of the FSM state, so there
// is no combinational path from any input to any output.
// Define YSYX_23060096_IFU_PERF_EN to build the perf_fetch_cnt and
// perf_stall_cnt counters and their ports; without it they are absent and
// the fetch behaviour is unchanged.
module ysyx_23060096_ifu #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic                  clk,
  input  logic                  rst_n,
`ifdef YSYX_23060096_IFU_PERF_EN
  output logic [31:0]           perf_fetch_cnt,
  output logic [31:0]           perf_stall_cnt,
`endif
  ysyx_23060096_ifu_if.master   bus
);

  // IDLE: one cycle after reset; REQ: request on the bus; WAIT: request
  // accepted, response pending; HOLD: instruction offered to decode;
  // DRAIN: a redirect orphaned the in-flight request, swallow its response.
  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    HOLD,
    DRAIN
  } state_t;

  state_t      r_state;
  state_t      w_nextState;
  logic [31:0] r_pc;
  logic [31:0] w_nextPc;
  logic [31:0] r_outPc;
  logic [31:0] r_outInst;
  logic        r_outFault;
  logic        w_capture;
  logic [31:0] w_redirPc;
  logic [31:0] w_seqPc;
  logic        w_outValid;

  // Redirect targets are forced word-aligned; the sequential PC wraps mod 2^32.
  assign w_redirPc  = bus.redirect_pc & 32'hFFFF_FFFC;
  assign w_seqPc    = r_pc + 32'd4;
  assign w_outValid = (r_state == HOLD);

  assign bus.imem_req_valid = (r_state == REQ);
  assign bus.imem_req_addr  = r_pc;
  assign bus.out_valid      = w_outValid;
  assign bus.out_pc         = r_outPc;
  assign bus.out_inst       = r_outInst;
  assign bus.out_fault      = r_outFault;

  // Next-state, next-PC and response-capture decode; a redirect always beats pc+4
  always_comb begin
    w_nextState = r_state;
    w_nextPc    = r_pc;
    w_capture   = 1'b0;
    case (r_state)
      IDLE: begin
        w_nextState = REQ;
      end
      REQ: begin
        if (bus.redirect_valid) begin
          w_nextPc = w_redirPc;
        end
        if (bus.imem_req_ready) begin
          w_nextState = bus.redirect_valid ? DRAIN : WAIT;
        end
      end
      WAIT: begin
        if (bus.redirect_valid) begin
          w_nextPc    = w_redirPc;
          w_nextState = bus.imem_rsp_valid ? REQ : DRAIN;
        end else if (bus.imem_rsp_valid) begin
          w_capture   = 1'b1;
          w_nextState = HOLD;
        end
      end
      HOLD: begin
        if (bus.redirect_valid) begin
          w_nextPc    = w_redirPc;
          w_nextState = REQ;
        end else if (bus.out_ready) begin
          w_nextPc    = w_seqPc;
          w_nextState = REQ;
        end
      end
      DRAIN: begin
        if (bus.redirect_valid) begin
          w_nextPc = w_redirPc;
        end
        if (bus.imem_rsp_valid) begin
          w_nextState = REQ;
        end
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // FSM state and PC registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_pc    <= RESET_PC;
    end else begin
      r_state <= w_nextState;
      r_pc    <= w_nextPc;
    end
  end

  // Output holding registers, loaded only by an accepted, non-redirected response
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_outPc    <= RESET_PC;
      r_outInst  <= 32'd0;
      r_outFault <= 1'b0;
    end else if (w_capture) begin
      r_outPc    <= r_pc;
      r_outInst  <= bus.imem_rsp_data;
      r_outFault <= bus.imem_rsp_err;
    end
  end

`ifdef YSYX_23060096_IFU_PERF_EN
  logic [31:0] r_fetchCnt;
  logic [31:0] r_stallCnt;
  logic        w_outFire;
  logic        w_outStall;

  assign w_outFire      = w_outValid && bus.out_ready;
  assign w_outStall     = w_outValid && !bus.out_ready;
  assign perf_fetch_cnt = r_fetchCnt;
  assign perf_stall_cnt = r_stallCnt;

  // Delivered-instruction and decode-backpressure counters, wrapping at 2^32
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_fetchCnt <= 32'd0;
      r_stallCnt <= 32'd0;
    end else begin
      if (w_outFire) begin
        r_fetchCnt <= r_fetchCnt + 32'd1;
      end
      if (w_outStall) begin
        r_stallCnt <= r_stallCnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_ysyx_23060096_ifu.sv
// tb_ysyx_23060096_ifu: self-checking bench for ysyx_23060096_ifu.
// A memory model answers accepted requests after a programmable delay and
// compares each request address against a queue of expected addresses; an
// output monitor compares each new instruction offered to decode against a
// queue of expected {pc, inst, fault}. The main sequence walks through
// reset, sequential fetch, backpressure, redirects, faults and mid-fetch reset.
`timescale 1ns/1ps
module tb_ysyx_23060096_ifu;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        fault;
  } outExp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  int          checkCount = 0;
  int          errCount = 0;
  int          cycleCnt = 0;
  int          rspDelay = 1;
  logic        useNop = 1'b1;
  logic [31:0] errAddr = 32'h0000_0000;
  logic [31:0] expReqQ[$];
  outExp_t     expOutQ[$];

`ifdef YSYX_23060096_IFU_PERF_EN
  logic [31:0] perfFetch;
  logic [31:0] perfStall;
`endif

  ysyx_23060096_ifu_if ifc();

  ysyx_23060096_ifu #(
    .RESET_PC(RESET_PC)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
`ifdef YSYX_23060096_IFU_PERF_EN
    .perf_fetch_cnt(perfFetch),
    .perf_stall_cnt(perfStall),
`endif
    .bus           (ifc)
  );

  // Free-running clock, 10 ns period
  always #5 clk = ~clk;

  // Cycle counter used to measure fetch spacing
  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  // Counts one comparison and reports it if observed differs from expected
  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checkCount++;
    if (got !== exp) begin
      errCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Instruction word the memory model returns for an address
  function automatic logic [31:0] memWord(input logic [31:0] a);
    return {~a[15:0], a[31:16]} ^ 32'h0000_0F0F;
  endfunction

  // Drives decode/redirect inputs just after the next rising edge
  task automatic applyStimulus(input logic ready, input logic rv, input logic [31:0] rpc);
    @(posedge clk);
    #1;
    ifc.out_ready      = ready;
    ifc.redirect_valid = rv;
    ifc.redirect_pc    = rpc;
  endtask

  // Called at a negedge; steps negedges until out_valid or the budget runs out
  task automatic waitOutValid(input int budget);
    int n = 0;
    while (ifc.out_valid !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput("wait_out_valid", ifc.out_valid, 1);
  endtask

  // Called at a negedge; steps negedges until a request is on the bus or the budget runs out
  task automatic waitReqValid(input int budget);
    int n = 0;
    while (ifc.imem_req_valid !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput("wait_req_valid", ifc.imem_req_valid, 1);
  endtask

  // Checks every output against its reset value
  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_req_valid"}, ifc.imem_req_valid, 0);
    checkOutput({tag, "_out_valid"}, ifc.out_valid, 0);
    checkOutput({tag, "_out_inst"}, ifc.out_inst, 0);
    checkOutput({tag, "_out_pc"}, ifc.out_pc, RESET_PC);
    checkOutput({tag, "_out_fault"}, ifc.out_fault, 0);
`ifdef YSYX_23060096_IFU_PERF_EN
    checkOutput({tag, "_perf_fetch"}, perfFetch, 0);
    checkOutput({tag, "_perf_stall"}, perfStall, 0);
`endif
  endtask

  // Memory model: single outstanding read, response rspDelay edges after acceptance, reset with rst_n
  initial begin : memModel
    logic        acceptSeen;
    logic        resetSeen;
    logic [31:0] pendAddr;
    logic        pendErr;
    int          remaining;
    acceptSeen = 1'b0;
    resetSeen  = 1'b0;
    pendAddr   = 32'd0;
    pendErr    = 1'b0;
    remaining  = 0;
    ifc.imem_req_ready = 1'b1;
    ifc.imem_rsp_valid = 1'b0;
    ifc.imem_rsp_data  = 32'd0;
    ifc.imem_rsp_err   = 1'b0;
    forever begin
      @(negedge clk);
      acceptSeen = (ifc.imem_req_valid === 1'b1) && (ifc.imem_req_ready === 1'b1) && (rst_n === 1'b1);
      resetSeen  = (rst_n !== 1'b1);
      if (acceptSeen) pendAddr = ifc.imem_req_addr;
      @(posedge clk);
      #1;
      ifc.imem_rsp_valid = 1'b0;
      ifc.imem_rsp_data  = 32'd0;
      ifc.imem_rsp_err   = 1'b0;
      if (resetSeen) begin
        remaining = 0;
      end else if (acceptSeen) begin
        checkOutput("req_expected", expReqQ.size() != 0, 1);
        if (expReqQ.size() != 0) checkOutput("req_addr", pendAddr, expReqQ.pop_front());
        remaining = rspDelay;
        pendErr   = (pendAddr == errAddr);
      end
      if (remaining > 0) begin
        if (remaining == 1) begin
          ifc.imem_rsp_valid = 1'b1;
          ifc.imem_rsp_data  = useNop ? NOP : memWord(pendAddr);
          ifc.imem_rsp_err   = pendErr;
        end
        remaining--;
      end
    end
  end

  // Output monitor: each newly offered instruction must match the next expected entry
  initial begin : outMonitor
    logic    prevValid;
    outExp_t e;
    prevValid = 1'b0;
    forever begin
      @(negedge clk);
      if (ifc.out_valid === 1'b1 && !prevValid) begin
        checkOutput("out_expected", expOutQ.size() != 0, 1);
        if (expOutQ.size() != 0) begin
          e = expOutQ.pop_front();
          checkOutput("mon_out_pc", ifc.out_pc, e.pc);
          checkOutput("mon_out_inst", ifc.out_inst, e.inst);
          checkOutput("mon_out_fault", ifc.out_fault, e.fault);
        end
      end
      prevValid = (ifc.out_valid === 1'b1);
    end
  end

  // Main directed sequence
  initial begin : mainSeq
    int cyc[3];
    ifc.out_ready      = 1'b1;
    ifc.redirect_valid = 1'b0;
    ifc.redirect_pc    = 32'd0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkResetOutputs("reset");

    // Sequential fetch of NOPs with a one-cycle memory
    for (int i = 0; i < 4; i++) begin
      expReqQ.push_back(RESET_PC + 32'(4 * i));
      expOutQ.push_back('{pc: RESET_PC + 32'(4 * i), inst: NOP, fault: 1'b0});
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("idle_req_valid", ifc.imem_req_valid, 0);
    @(negedge clk);
    checkOutput("first_req_valid", ifc.imem_req_valid, 1);
    checkOutput("first_req_addr", ifc.imem_req_addr, RESET_PC);
    for (int i = 0; i < 3; i++) begin
      waitOutValid(10);
      cyc[i] = cycleCnt;
      if (i < 2) @(negedge clk);
    end
    checkOutput("seq_gap_1", cyc[1] - cyc[0], 3);
    checkOutput("seq_gap_2", cyc[2] - cyc[1], 3);
    applyStimulus(1'b0, 1'b0, 32'd0);
    @(negedge clk);

    // Backpressure: five stalled cycles in HOLD, then consume
    waitOutValid(10);
    for (int i = 1; i <= 5; i++) begin
      applyStimulus(i == 5, 1'b0, 32'd0);
      @(negedge clk);
      checkOutput("bp_out_valid", ifc.out_valid, 1);
      checkOutput("bp_out_pc", ifc.out_pc, 32'h8000_000C);
      checkOutput("bp_out_inst", ifc.out_inst, NOP);
      checkOutput("bp_req_valid", ifc.imem_req_valid, 0);
    end
`ifdef YSYX_23060096_IFU_PERF_EN
    checkOutput("bp_perf_stall", perfStall, 5);
`endif
    applyStimulus(1'b0, 1'b0, 32'd0);
    @(negedge clk);
`ifdef YSYX_23060096_IFU_PERF_EN
    checkOutput("bp_perf_fetch", perfFetch, 4);
`endif

    // Redirect while waiting on a slow response; the stale word must be dropped
    useNop   = 1'b0;
    rspDelay = 3;
    expReqQ.push_back(32'h8000_0010);
    expReqQ.push_back(32'h8000_1000);
    expOutQ.push_back('{pc: 32'h8000_1000, inst: memWord(32'h8000_1000), fault: 1'b0});
    waitReqValid(10);
    applyStimulus(1'b0, 1'b1, 32'h8000_1000);
    applyStimulus(1'b0, 1'b0, 32'd0);
    @(negedge clk);
    waitOutValid(30);
    checkOutput("redir_out_pc", ifc.out_pc, 32'h8000_1000);

    // Redirect and consume in the same HOLD cycle; target low bits dropped, next word faults
    rspDelay = 1;
    errAddr  = 32'h8000_0200;
    expReqQ.push_back(32'h8000_0200);
    expOutQ.push_back('{pc: 32'h8000_0200, inst: memWord(32'h8000_0200), fault: 1'b1});
    applyStimulus(1'b1, 1'b1, 32'h8000_0203);
    applyStimulus(1'b0, 1'b0, 32'd0);
    @(negedge clk);
    checkOutput("rr_req_valid", ifc.imem_req_valid, 1);
    checkOutput("rr_req_addr", ifc.imem_req_addr, 32'h8000_0200);
`ifdef YSYX_23060096_IFU_PERF_EN
    checkOutput("rr_perf_fetch", perfFetch, 5);
`endif

    // Faulting fetch, then a clean one clears the fault flag
    waitOutValid(10);
    checkOutput("fault_flag", ifc.out_fault, 1);
    checkOutput("fault_pc", ifc.out_pc, 32'h8000_0200);
    expReqQ.push_back(32'h8000_0204);
    expOutQ.push_back('{pc: 32'h8000_0204, inst: memWord(32'h8000_0204), fault: 1'b0});
    applyStimulus(1'b1, 1'b0, 32'd0);
    applyStimulus(1'b0, 1'b0, 32'd0);
    @(negedge clk);
    waitOutValid(10);
    checkOutput("clear_fault_flag", ifc.out_fault, 0);
    checkOutput("clear_fault_pc", ifc.out_pc, 32'h8000_0204);

    // Reset for one cycle while a fetch is in WAIT
    rspDelay = 3;
    expReqQ.push_back(32'h8000_0208);
    applyStimulus(1'b1, 1'b0, 32'd0);
    applyStimulus(1'b0, 1'b0, 32'd0);
    @(negedge clk);
    waitReqValid(10);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    checkResetOutputs("midrst");
    rspDelay = 2;
    expReqQ.push_back(RESET_PC);
    expOutQ.push_back('{pc: RESET_PC, inst: memWord(RESET_PC), fault: 1'b0});
    waitReqValid(10);
    checkOutput("midrst_req_addr", ifc.imem_req_addr, RESET_PC);
    @(negedge clk);
    waitOutValid(10);
    checkOutput("midrst_out_pc", ifc.out_pc, RESET_PC);

    // Every expected request and instruction must have been seen
    checkOutput("req_queue_drained", expReqQ.size(), 0);
    checkOutput("out_queue_drained", expOutQ.size(), 0);

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
